// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Sequences a single-ported instruction/data RAM between the fetch stage and
// the load/store stage. Exactly one transaction is in flight at a time:
//
//   IDLE -> ACCESS -> (WAIT x MEM_LAT for reads) -> RESP -> IDLE
//
// Requests, grant, address and store data are captured in IDLE, so the
// requesters may change or drop their inputs once granted without affecting
// the transaction. Data requests win over fetch, except that a fetch always
// wins straight after a data grant, so neither side can be starved.
//
// Parameters
//   ADDR_W   word-address width shared by fetch, data and RAM ports
//   DATA_W   data/instruction width
//   MEM_LAT  cycles from the mem_ren cycle to valid mem_rdata (1..4)
//
// Ports
//   i_clk         rising-edge clock
//   i_rst         synchronous, active-high reset
//   i_if_req      fetch request (level, held until o_if_ready)
//   i_if_addr     fetch word address
//   o_if_instr    fetched instruction, valid with o_if_ready, held afterwards
//   o_if_ready    one-cycle pulse: o_if_instr is valid
//   o_pc_enable   identical to o_if_ready; the PC may advance
//   i_dm_read     load request (level, held until o_dm_done)
//   i_dm_write    store request (level, held until o_dm_done)
//   i_dm_addr     data word address
//   i_dm_wdata    store data
//   o_dm_rdata    load data, valid with o_dm_done after a load, held afterwards
//   o_dm_done     one-cycle pulse: load or store completed
//   o_mem_addr    RAM address (0 outside ACCESS)
//   o_mem_ren     RAM read enable
//   o_mem_wen     RAM write enable
//   o_mem_wdata   RAM write data (0 outside a store ACCESS)
//   i_mem_rdata   RAM read data
//   o_busy        high whenever the FSM is not in IDLE
// -----------------------------------------------------------------------------
module mem_arbiter #(
   parameter int unsigned ADDR_W  = 5,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned MEM_LAT = 1
) (
   input  logic              i_clk,
   input  logic              i_rst,
   // fetch port
   input  logic              i_if_req,
   input  logic [ADDR_W-1:0] i_if_addr,
   output logic [DATA_W-1:0] o_if_instr,
   output logic              o_if_ready,
   output logic              o_pc_enable,
   // load/store port
   input  logic              i_dm_read,
   input  logic              i_dm_write,
   input  logic [ADDR_W-1:0] i_dm_addr,
   input  logic [DATA_W-1:0] i_dm_wdata,
   output logic [DATA_W-1:0] o_dm_rdata,
   output logic              o_dm_done,
   // RAM port
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic              o_mem_ren,
   output logic              o_mem_wen,
   output logic [DATA_W-1:0] o_mem_wdata,
   input  logic [DATA_W-1:0] i_mem_rdata,
   // status
   output logic              o_busy
);

   // Down-counter only has to hold MEM_LAT-1 (at most 3).
   localparam int unsigned CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);

   typedef enum logic [1:0] {
      StIdle,
      StAccess,
      StWait,
      StResp
   } state_t;

   state_t r_state;
   state_t w_state_next;

   // Transaction context captured in IDLE.
   logic              r_last_data;  // last grant went to the data port
   logic              r_gnt_data;   // current transaction belongs to the data port
   logic              r_is_write;   // current transaction is a store
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic [CNT_W-1:0]  r_cnt;
   logic [DATA_W-1:0] r_if_instr;
   logic [DATA_W-1:0] r_dm_rdata;

   // Arbitration
   logic w_dm_req;
   logic w_grant_data;
   logic w_grant_fetch;
   logic w_grant_any;
   logic w_capture;

   assign w_dm_req      = i_dm_read | i_dm_write;
   // A pending fetch always beats data right after a data grant.
   assign w_grant_data  = w_dm_req & ~(r_last_data & i_if_req);
   assign w_grant_fetch = i_if_req & ~w_grant_data;
   assign w_grant_any   = w_grant_data | w_grant_fetch;

   // Read data is valid in the last WAIT cycle.
   assign w_capture = (r_state == StWait) && (r_cnt == '0);

   // FSM state register
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_next;
      end
   end

   // FSM next state and RAM/handshake outputs
   always_comb begin
      w_state_next = r_state;
      o_mem_addr   = '0;
      o_mem_ren    = 1'b0;
      o_mem_wen    = 1'b0;
      o_mem_wdata  = '0;
      o_if_ready   = 1'b0;
      o_dm_done    = 1'b0;

      unique case (r_state)
         StIdle: begin
            if (w_grant_any) begin
               w_state_next = StAccess;
            end
         end

         StAccess: begin
            o_mem_addr = r_addr;
            if (r_is_write) begin
               o_mem_wen    = 1'b1;
               o_mem_wdata  = r_wdata;
               w_state_next = StResp;
            end else begin
               o_mem_ren    = 1'b1;
               w_state_next = StWait;
            end
         end

         StWait: begin
            if (r_cnt == '0) begin
               w_state_next = StResp;
            end
         end

         StResp: begin
            if (r_gnt_data) begin
               o_dm_done = 1'b1;
            end else begin
               o_if_ready = 1'b1;
            end
            w_state_next = StIdle;
         end

         default: begin
            w_state_next = StIdle;
         end
      endcase
   end

   // Datapath: grant context, latency counter and read-data holding registers
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_last_data <= 1'b0;
         r_gnt_data  <= 1'b0;
         r_is_write  <= 1'b0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_cnt       <= '0;
         r_if_instr  <= '0;
         r_dm_rdata  <= '0;
      end else begin
         if ((r_state == StIdle) && w_grant_any) begin
            r_gnt_data  <= w_grant_data;
            r_last_data <= w_grant_data;
            // A simultaneous read+write is treated as a store only.
            r_is_write  <= w_grant_data & i_dm_write;
            r_addr      <= w_grant_data ? i_dm_addr : i_if_addr;
            r_wdata     <= i_dm_wdata;
         end

         if (r_state == StAccess) begin
            r_cnt <= CNT_LOAD;
         end else if ((r_state == StWait) && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
         end

         if (w_capture) begin
            if (r_gnt_data) begin
               r_dm_rdata <= i_mem_rdata;
            end else begin
               r_if_instr <= i_mem_rdata;
            end
         end
      end
   end

   assign o_if_instr  = r_if_instr;
   assign o_dm_rdata  = r_dm_rdata;
   assign o_pc_enable = o_if_ready;
   assign o_busy      = (r_state != StIdle);

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Scoreboard bench for mem_arbiter. A stimulus process issues rounds of
// fetch/load/store requests; for each round a transaction-level model
// (arbitration rule, latency rule, word array) pushes the expected responses,
// in order, into a queue. A monitor process pops and compares whenever the DUT
// pulses o_if_ready or o_dm_done. A behavioural RAM with MEM_LAT read latency
// sits on the memory port.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

   localparam int LAT = 1;

   typedef struct {
      bit          is_fetch;
      logic [31:0] data;
      int          cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req;
   logic [4:0]  if_addr;
   logic [31:0] if_instr;
   logic        if_ready;
   logic        pc_enable;
   logic        dm_read;
   logic        dm_write;
   logic [4:0]  dm_addr;
   logic [31:0] dm_wdata;
   logic [31:0] dm_rdata;
   logic        dm_done;
   logic [4:0]  mem_addr;
   logic        mem_ren;
   logic        mem_wen;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        busy;

   always #5 clk = ~clk;

   mem_arbiter #(
      .ADDR_W (5),
      .DATA_W (32),
      .MEM_LAT(LAT)
   ) dut (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_if_req   (if_req),
      .i_if_addr  (if_addr),
      .o_if_instr (if_instr),
      .o_if_ready (if_ready),
      .o_pc_enable(pc_enable),
      .i_dm_read  (dm_read),
      .i_dm_write (dm_write),
      .i_dm_addr  (dm_addr),
      .i_dm_wdata (dm_wdata),
      .o_dm_rdata (dm_rdata),
      .o_dm_done  (dm_done),
      .o_mem_addr (mem_addr),
      .o_mem_ren  (mem_ren),
      .o_mem_wen  (mem_wen),
      .o_mem_wdata(mem_wdata),
      .i_mem_rdata(mem_rdata),
      .o_busy     (busy)
   );

   // Behavioural RAM: data for the address seen in cycle c appears in c+LAT.
   logic [31:0] ram  [32];
   logic [31:0] pipe [LAT];

   initial begin
      forever begin
         @(posedge clk);
         if (mem_wen) ram[mem_addr] <= mem_wdata;
         pipe[0] <= ram[mem_addr];
         for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
      end
   end
   assign mem_rdata = pipe[LAT-1];

   // Cycle index: cycle k is the interval after the k-th rising edge.
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboard and model state
   exp_t        q[$];
   int          n_cmp = 0;
   int          n_bad = 0;
   int          n_ren = 0;
   int          n_wen = 0;
   int          exp_ren = 0;
   int          exp_wen = 0;
   bit          armed = 0;
   bit          m_last_data;
   logic [31:0] m_load;
   logic [31:0] m_instr;
   logic [31:0] mem_m [32];

   function automatic void check(input string name, input logic [63:0] act,
                                 input logic [63:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
      end
   endfunction

   // Monitor
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (armed) begin
            if (mem_wen) n_wen++;
            if (mem_ren) n_ren++;
            check("pc_enable_eq_ready", pc_enable, if_ready);
            if (mem_ren || mem_wen) check("busy_during_access", busy, 1);
            if (if_ready || dm_done) begin
               check("single_pulse", if_ready & dm_done, 0);
               check("resp_expected", q.size() > 0, 1);
               if (q.size() > 0) begin
                  e = q.pop_front();
                  check("resp_kind_fetch", if_ready, e.is_fetch);
                  check("resp_cycle", cyc, e.cyc);
                  if (e.is_fetch) check("if_instr", if_instr, e.data);
                  else check("dm_rdata", dm_rdata, e.data);
               end
            end
         end
      end
   end

   // One round: the given requests are raised together from IDLE and each is
   // held until its own completion pulse.
   task automatic round(input bit f, input bit rd, input bit wr, input logic [4:0] fa,
                        input logic [4:0] da, input logic [31:0] wd, input bit perturb);
      int   t;
      int   need;
      int   got;
      bit   dm;
      bit   data_first;
      bit   sd;
      exp_t e;
      @(negedge clk);
      #1;
      t          = cyc;
      dm         = rd | wr;
      need       = int'(f) + int'(dm);
      data_first = dm && !(m_last_data && f);
      for (int s = 0; s < need; s++) begin
         sd = (need == 1) ? dm : ((s == 0) == data_first);
         if (sd) begin
            e.is_fetch = 0;
            if (wr) begin
               mem_m[da] = wd;
               e.data    = m_load;
               t        += 2;
               exp_wen++;
            end else begin
               m_load = mem_m[da];
               e.data = m_load;
               t     += 2 + LAT;
               exp_ren++;
            end
            m_last_data = 1;
         end else begin
            e.is_fetch  = 1;
            m_instr     = mem_m[fa];
            e.data      = m_instr;
            t          += 2 + LAT;
            exp_ren++;
            m_last_data = 0;
         end
         e.cyc = t;
         q.push_back(e);
         t += 1;  // next request is sampled in the IDLE cycle after RESP
      end
      if_req   = f;
      if_addr  = fa;
      dm_read  = rd;
      dm_write = wr;
      dm_addr  = da;
      dm_wdata = wd;
      got      = 0;
      for (int c = 0; c < 40 && got < need; c++) begin
         @(negedge clk);
         #1;
         if (dm_done) begin
            got++;
            dm_read  = 0;
            dm_write = 0;
         end
         if (if_ready) begin
            got++;
            if_req = 0;
         end
         if (perturb && c == 0) begin
            // Drop the request and scramble inputs after the grant.
            if_req   = 0;
            dm_read  = 0;
            dm_write = 0;
            if_addr  = 5'($urandom);
            dm_addr  = 5'($urandom);
            dm_wdata = $urandom;
         end
      end
      check("round_served", got, need);
   endtask

   initial begin
      int          kind;
      int          dk;
      bit          f;
      bit          rd;
      bit          wr;
      logic [31:0] w;
      rst      = 1;
      if_req   = 0;
      if_addr  = 0;
      dm_read  = 0;
      dm_write = 0;
      dm_addr  = 0;
      dm_wdata = 0;
      for (int i = 0; i < 32; i++) begin
         w        = $urandom;
         ram[i]   = w;
         mem_m[i] = w;
      end
      ram[3]   = 32'hDEAD_BEEF;
      mem_m[3] = 32'hDEAD_BEEF;

      // Reset with every request raised
      @(negedge clk);
      if_req   = 1;
      dm_read  = 1;
      dm_write = 1;
      if_addr  = 5'd7;
      dm_addr  = 5'd9;
      dm_wdata = 32'hFFFF_FFFF;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_if_ready", if_ready, 0);
      check("rst_pc_enable", pc_enable, 0);
      check("rst_dm_done", dm_done, 0);
      check("rst_mem_ren", mem_ren, 0);
      check("rst_mem_wen", mem_wen, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_mem_wdata", mem_wdata, 0);
      check("rst_busy", busy, 0);
      check("rst_if_instr", if_instr, 0);
      check("rst_dm_rdata", dm_rdata, 0);
      rst         = 0;
      if_req      = 0;
      dm_read     = 0;
      dm_write    = 0;
      m_last_data = 0;
      m_load      = 0;
      m_instr     = 0;
      armed       = 1;

      // Fetch of word 3
      round(1, 0, 0, 5'd3, 5'd0, 32'h0, 0);
      // Store then load of word 2
      round(0, 0, 1, 5'd0, 5'd2, 32'h1234_5678, 0);
      round(0, 1, 0, 5'd0, 5'd2, 32'h0, 0);
      // Fetch so the next contention starts from last grant = FETCH
      round(1, 0, 0, 5'd5, 5'd0, 32'h0, 0);
      // Contention twice: DATA, FETCH, DATA, FETCH
      round(1, 1, 0, 5'd6, 5'd3, 32'h0, 0);
      round(1, 1, 0, 5'd8, 5'd2, 32'h0, 0);
      // Read and write together: store only, then read the word back
      round(0, 1, 1, 5'd0, 5'd4, 32'hA5A5_A5A5, 0);
      round(0, 1, 0, 5'd0, 5'd4, 32'h0, 0);

      // Reset during WAIT aborts the load silently
      @(negedge clk);
      #1;
      dm_read = 1;
      dm_addr = 5'd4;
      exp_ren++;
      repeat (2) @(negedge clk);
      #1;
      rst     = 1;
      dm_read = 0;
      @(negedge clk);
      check("abort_busy", busy, 0);
      check("abort_mem_ren", mem_ren, 0);
      check("abort_dm_rdata", dm_rdata, 0);
      #1;
      rst         = 0;
      m_last_data = 0;
      m_load      = 0;
      m_instr     = 0;
      round(0, 1, 0, 5'd0, 5'd2, 32'h0, 0);

      // Random rounds
      for (int r = 0; r < 40; r++) begin
         kind = $urandom_range(0, 2);
         dk   = $urandom_range(0, 3);
         f    = (kind != 1);
         rd   = (kind != 0) && (dk != 2);
         wr   = (kind != 0) && (dk >= 2);
         repeat ($urandom_range(0, 2)) @(negedge clk);
         round(f, rd, wr, 5'($urandom), 5'($urandom), $urandom,
               (kind != 2) && ($urandom_range(0, 1) == 1));
      end

      repeat (4) @(negedge clk);
      check("queue_empty", q.size(), 0);
      check("mem_wen_count", n_wen, exp_wen);
      check("mem_ren_count", n_ren, exp_ren);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

endmodule
